adder_result_accumulator: RTL and testbench
===========================================

// Module: adder_result_accumulator
// PURPOSE
//  Downstream stage of carry_lookahead_adder. Takes its WIDTH+1-bit o_result
//  stream over a valid/ready handshake and sums COUNT consecutive results (or
//  fewer, on flush) into a saturating accumulator. Each finished block total
//  goes out on a valid/ready output port.
// PARAMETERS
//  WIDTH      8   adder operand width; input sample is WIDTH+1 bits
//  ACC_WIDTH  16  accumulator/output width; must be >= WIDTH+1
//  COUNT      4   samples per block; must be >= 1
// PORTS
//  i_clk      in   1             single clock, all logic on rising edge
//  i_rst      in   1             synchronous reset, active-high
//  i_valid    in   1             i_sum valid
//  o_ready    out  1             block can accept a sample this cycle
//  i_sum      in   WIDTH+1       adder o_result (unsigned)
//  i_flush    in   1             close the current block early
//  o_valid    out  1             o_acc/o_count/o_ovf hold a finished block
//  i_ready    in   1             consumer accepts the finished block
//  o_acc      out  ACC_WIDTH     block total, saturated
//  o_count    out  $clog2(COUNT+1)  samples in the finished block
//  o_ovf      out  1             saturation happened somewhere in this block
// BEHAVIOUR
//  Reset (i_rst=1 at posedge): state=ACCUM, acc=0, cnt=0, ovf=0, o_valid=0,
//   o_acc=0, o_count=0, o_ovf=0. o_ready=1 from the first cycle after reset.
//   Reset wins over every other input. A partial block is discarded.
//  States: ACCUM (o_ready=1, o_valid=0) and DONE (o_ready=0, o_valid=1).
//  Accept = i_valid & o_ready. On accept: acc <= sat(acc + zext(i_sum)),
//   cnt <= cnt+1. Addition uses ACC_WIDTH+1 bits. If the result is
//   > 2^ACC_WIDTH-1, acc is clamped to all-ones and ovf is set (sticky per block).
//  Block close happens at the same edge as either:
//   a) the accept that brings cnt to COUNT, or
//   b) i_flush=1 in ACCUM with (cnt>0 or an accept this cycle).
//   On close, o_acc/o_count/o_ovf load the post-accept values (a sample
//   accepted in the same cycle is included) and state -> DONE.
//   Latency: o_valid rises 1 cycle after the closing edge.
//  i_flush with cnt=0 and no accept: ignored, no output.
//  i_flush in DONE: ignored.
//  DONE: o_acc/o_count/o_ovf stay stable while o_valid & !i_ready.
//   On o_valid & i_ready: state -> ACCUM, acc/cnt/ovf cleared, o_valid=0 next
//   cycle. No sample is taken in the handover cycle because o_ready=0.
//  Outputs keep their last block values after the handshake, but they are
//   meaningful only while o_valid=1.
//  COUNT=1: every accept closes a block, so throughput is 1 sample per 2 cycles.
//  Max throughput: COUNT samples per COUNT+1 cycles when i_ready is tied high.
//  i_valid may drop between samples: cnt holds and there is no timeout.
//  If a sample is offered while o_ready=0, the producer must keep it until
//   it is accepted.
// TESTING  (WIDTH=8, ACC_WIDTH=10, COUNT=4, i_ready=1 unless stated)
//  1 Stream 100,200,300,400 back-to-back -> 1 cycle after 4th accept
//    o_valid=1, o_acc=1000, o_count=4, o_ovf=0; o_ready=0 for exactly 1 cycle.
//  2 Stream 511,511,511,10 -> o_acc=1023 (clamped), o_ovf=1, o_count=4;
//    next block 1,1,1,1 -> o_acc=4, o_ovf=0 (sticky flag cleared per block).
//  3 Backpressure: block 1,2,3,4 done, hold i_ready=0 for 5 cycles while
//    i_valid=1 -> o_acc=10 stable, o_ready=0, no sample lost; samples resume
//    being accepted the cycle after i_ready=1.
//  4 Flush: accept 5,7, then i_flush=1 with i_valid=0 -> o_acc=12, o_count=2.
//    i_flush with accept 9 in the same cycle after 3 -> o_acc=12, o_count=2.
//    i_flush on an empty block -> no o_valid.
//  5 Reset: accept 50,60, assert i_rst for 1 cycle -> all outputs 0, o_ready=1;
//    then 1,2,3,4 -> o_acc=10 (earlier partial block discarded).
//  6 Random i_valid/i_ready/i_flush for 10k cycles against a reference model:
//    every block total, count and ovf flag matches; no output changes while
//    stalled.

Source files
------------

// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator: sums COUNT adder results (or fewer on flush) into a
// saturating total and hands each finished block out over valid/ready.
module adder_result_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int COUNT     = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [WIDTH:0]               i_sum,
    input  logic                         i_flush,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [ACC_WIDTH-1:0]         o_acc,
    output logic [$clog2(COUNT+1)-1:0]   o_count,
    output logic                         o_ovf
);
    localparam int CW = $clog2(COUNT+1);
    typedef enum logic {ACCUM, DONE} state_t;
    state_t               r_state, w_next;
    logic [ACC_WIDTH-1:0] r_acc, r_out_acc, w_acc;
    logic [CW-1:0]        r_cnt, r_out_cnt, w_cnt;
    logic                 r_ovf, r_out_ovf, w_ovf, w_accept, w_close;
    logic [ACC_WIDTH:0]   w_sum;
    // w_acc/w_cnt/w_ovf are the post-accept values, so a closing sample is included
    always_comb begin
        w_accept = i_valid && r_state == ACCUM;
        w_sum    = {1'b0, r_acc} + (ACC_WIDTH+1)'(i_sum);
        w_acc    = w_accept ? (w_sum[ACC_WIDTH] ? '1 : w_sum[ACC_WIDTH-1:0]) : r_acc;
        w_cnt    = w_accept ? r_cnt + CW'(1) : r_cnt;
        w_ovf    = r_ovf | (w_accept & w_sum[ACC_WIDTH]);
        w_close  = r_state == ACCUM && (w_cnt == CW'(COUNT) || (i_flush && w_cnt != '0));
        w_next   = w_close ? DONE : (r_state == DONE && i_ready) ? ACCUM : r_state;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ACCUM;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_acc <= '0;
            r_out_cnt <= '0;
            r_out_ovf <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_close) begin
                r_out_acc <= w_acc;
                r_out_cnt <= w_cnt;
                r_out_ovf <= w_ovf;
                r_acc     <= '0;
                r_cnt     <= '0;
                r_ovf     <= 1'b0;
            end else begin
                r_acc <= w_acc;
                r_cnt <= w_cnt;
                r_ovf <= w_ovf;
            end
        end
    end
    assign o_ready = r_state == ACCUM;
    assign o_valid = r_state == DONE;
    assign o_acc   = r_out_acc;
    assign o_count = r_out_cnt;
    assign o_ovf   = r_out_ovf;
endmodule

// File: tb/tb_adder_result_accumulator.sv
// tb_adder_result_accumulator: scoreboard bench; a block model pushes expected
// totals when stimulus closes a block, popped when o_valid appears.
module tb_adder_result_accumulator;
    localparam int W  = 8;
    localparam int AW = 10;
    localparam int N  = 4;
    localparam int CW = 3;
    logic          clk = 0, rst = 1, iv = 0, fl = 0, ir = 1;
    logic [W:0]    s = '0;
    logic          o_ready, o_valid, o_ovf;
    logic [AW-1:0] o_acc;
    logic [CW-1:0] o_count;
    always #5 clk = ~clk;
    adder_result_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .COUNT(N)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(iv), .o_ready(o_ready), .i_sum(s),
        .i_flush(fl), .o_valid(o_valid), .i_ready(ir), .o_acc(o_acc),
        .o_count(o_count), .o_ovf(o_ovf)
    );
    typedef struct {int acc; int cnt; int ovf;} blk_t;
    blk_t q[$];
    blk_t cur;
    int   m_acc = 0, m_cnt = 0, m_ovf = 0, n_chk = 0, n_fail = 0;
    bit   m_done = 0, have = 0, m_rst = 1;
    task automatic check(input string tag, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask
    // checks the state reached at the last edge, then drives and models the next one
    task automatic cyc(input bit r_st, input bit v, input int sv, input bit f, input bit r, output bit a);
        @(negedge clk);
        check("o_valid", o_valid, int'(m_done));
        check("o_ready", o_ready, int'(!m_done));
        if (m_rst) begin
            check("rst_acc", o_acc, 0);
            check("rst_count", o_count, 0);
            check("rst_ovf", o_ovf, 0);
        end
        if (m_done) begin
            if (!have) begin
                check("blocks_pending", q.size(), 1);
                if (q.size() > 0) begin
                    cur  = q.pop_front();
                    have = 1;
                end
            end
            check("o_acc", o_acc, cur.acc);
            check("o_count", o_count, cur.cnt);
            check("o_ovf", o_ovf, cur.ovf);
        end
        m_rst = 0;
        rst = r_st; iv = v; s = (W+1)'(sv); fl = f; ir = r; a = 0;
        if (r_st) begin
            q.delete();
            m_acc = 0; m_cnt = 0; m_ovf = 0; m_done = 0; have = 0; m_rst = 1;
        end else if (m_done) begin
            if (r) begin m_done = 0; have = 0; end
        end else begin
            a = v;
            if (v) begin
                m_acc += sv;
                if (m_acc > 1023) begin m_acc = 1023; m_ovf = 1; end
                m_cnt++;
            end
            if (m_cnt == N || (f && m_cnt > 0)) begin
                q.push_back('{m_acc, m_cnt, m_ovf});
                m_acc = 0; m_cnt = 0; m_ovf = 0; m_done = 1;
            end
        end
    endtask
    initial begin
        bit a, pv, pa;
        int ps;
        cyc(0, 1, 100, 0, 1, a); cyc(0, 1, 200, 0, 1, a);
        cyc(0, 1, 300, 0, 1, a); cyc(0, 1, 400, 0, 1, a);
        cyc(0, 1, 511, 0, 1, a); cyc(0, 1, 511, 0, 1, a);
        cyc(0, 1, 511, 0, 1, a); cyc(0, 1, 10, 0, 1, a);
        cyc(0, 1, 1, 0, 1, a);   cyc(0, 1, 1, 0, 1, a);
        cyc(0, 1, 1, 0, 1, a);   cyc(0, 1, 1, 0, 1, a);
        cyc(0, 0, 0, 0, 1, a);
        cyc(0, 1, 1, 0, 0, a);   cyc(0, 1, 2, 0, 0, a);
        cyc(0, 1, 3, 0, 0, a);   cyc(0, 1, 4, 0, 0, a);
        for (int i = 0; i < 5; i++) cyc(0, 1, 5, 0, 0, a);
        cyc(0, 1, 5, 0, 1, a);   cyc(0, 1, 5, 0, 1, a);
        cyc(0, 1, 6, 0, 1, a);   cyc(0, 1, 7, 0, 1, a);
        cyc(0, 1, 8, 0, 1, a);
        cyc(0, 0, 0, 0, 1, a);
        cyc(0, 1, 5, 0, 1, a);   cyc(0, 1, 7, 0, 1, a);
        cyc(0, 0, 0, 1, 1, a);   cyc(0, 0, 0, 0, 1, a);
        cyc(0, 1, 3, 0, 1, a);   cyc(0, 1, 9, 1, 1, a);
        cyc(0, 0, 0, 0, 1, a);   cyc(0, 0, 0, 1, 1, a);
        cyc(0, 0, 0, 0, 1, a);   cyc(0, 0, 0, 0, 1, a);
        cyc(0, 1, 50, 0, 1, a);  cyc(0, 1, 60, 0, 1, a);
        cyc(1, 0, 0, 0, 1, a);
        cyc(0, 1, 1, 0, 1, a);   cyc(0, 1, 2, 0, 1, a);
        cyc(0, 1, 3, 0, 1, a);   cyc(0, 1, 4, 0, 1, a);
        cyc(0, 0, 0, 1, 1, a);   cyc(0, 0, 0, 0, 1, a);
        pv = 0; pa = 1; ps = 0;
        for (int i = 0; i < 10000; i++) begin
            if (!(pv && !pa)) begin
                pv = $urandom_range(3) != 0;
                ps = $urandom_range(1) != 0 ? int'($urandom_range(511)) : int'($urandom_range(63));
            end
            cyc(0, pv, ps, $urandom_range(7) == 0, $urandom_range(2) != 0, pa);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, a);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
